// File: rtl/pipe_rca_addsub.sv
// pipe_rca_addsub
//   Pipelined ripple-carry adder/subtractor. The DATA_WID-bit add is split into
//   NUM_STAGES = DATA_WID/SEG_WID segments, one segment per register stage. Each
//   stage adds its segment using the registered carry of the stage before it.
//   Operand segments not yet consumed travel along with the data (skew), and
//   sum segments already produced are carried forward (de-skew). As a result,
//   all result bits of one operand set leave the last stage together.
//   Subtraction is folded into the add at the input: the second operand is
//   inverted and the borrow-in is inverted. The operation mode therefore rides
//   down the pipe implicitly, inside the operand bits.
//   Flow control is a single global advance: the whole pipe moves only when
//   the output slot is empty or is being consumed.
//
// Parameters
//   DATA_WID     operand/result width; must be an integer multiple of SEG_WID
//   SEG_WID      bits added per stage (SEG_WID = DATA_WID gives one stage)
//
// Ports
//   Clock        rising-edge clock
//   Reset        synchronous active-high reset; flushes every stage
//   InValid      operand set offered on InputA/InputB/CarryInput/SubMode
//   InReady      operand set is accepted this cycle (equals advance)
//   InputA       first operand
//   InputB       second operand
//   CarryInput   carry-in when adding, borrow-in when subtracting
//   SubMode      0 = add, 1 = subtract
//   OutValid     Sum/CarryOutput/Overflow hold a completed result
//   OutReady     consumer takes the result this cycle
//   Sum          result
//   CarryOutput  carry out of the MSB (1 = no borrow when subtracting)
//   Overflow     two's-complement signed overflow

module pipe_rca_addsub #(
   parameter int DATA_WID = 64,
   parameter int SEG_WID  = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                InValid,
   output logic                InReady,
   input  logic [DATA_WID-1:0] InputA,
   input  logic [DATA_WID-1:0] InputB,
   input  logic                CarryInput,
   input  logic                SubMode,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [DATA_WID-1:0] Sum,
   output logic                CarryOutput,
   output logic                Overflow
);

   localparam int NUM_STAGES = DATA_WID / SEG_WID;

   logic                advance;
   logic [DATA_WID-1:0] b_eff;
   logic                c_eff;

   // The pipe moves as one unit; a held output freezes every stage behind it.
   assign advance = !OutValid || OutReady;
   assign InReady = advance;

   // a - b - c == a + ~b + ~c, so subtraction becomes an add from here on.
   assign b_eff = SubMode ? ~InputB : InputB;
   assign c_eff = CarryInput ^ SubMode;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      // Number of low result bits complete once this stage has registered.
      localparam int done_wid = (k + 1) * SEG_WID;

      logic [SEG_WID-1:0]  seg_a;
      logic [SEG_WID-1:0]  seg_b;
      logic                seg_cin;
      logic                vld_in;
      logic [SEG_WID:0]    seg_res;
      logic [done_wid-1:0] sum_d;
      logic [done_wid-1:0] sum_q;
      logic                vld_q;
      logic                cy_q;

      assign seg_res = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_WID{1'b0}}, seg_cin};

      if (k == 0) begin : g_src
         assign seg_a   = InputA[SEG_WID-1:0];
         assign seg_b   = b_eff[SEG_WID-1:0];
         assign seg_cin = c_eff;
         assign vld_in  = InValid;
         assign sum_d   = seg_res[SEG_WID-1:0];
      end else begin : g_src
         // The next segment to add always sits at the bottom of the skew registers.
         assign seg_a   = g_stage[k-1].g_rest.a_q[SEG_WID-1:0];
         assign seg_b   = g_stage[k-1].g_rest.b_q[SEG_WID-1:0];
         assign seg_cin = g_stage[k-1].cy_q;
         assign vld_in  = g_stage[k-1].vld_q;
         assign sum_d   = {seg_res[SEG_WID-1:0], g_stage[k-1].sum_q};
      end

      always_ff @(posedge Clock) begin
         if (Reset) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (advance) begin
            vld_q <= vld_in;
            cy_q  <= seg_res[SEG_WID];
            sum_q <= sum_d;
         end
      end

      if (k < NUM_STAGES - 1) begin : g_rest
         // Operand segments that later stages still have to add.
         localparam int rest_wid = DATA_WID - done_wid;

         logic [rest_wid-1:0] a_d;
         logic [rest_wid-1:0] b_d;
         logic [rest_wid-1:0] a_q;
         logic [rest_wid-1:0] b_q;

         if (k == 0) begin : g_rsrc
            assign a_d = InputA[DATA_WID-1:SEG_WID];
            assign b_d = b_eff[DATA_WID-1:SEG_WID];
         end else begin : g_rsrc
            assign a_d = g_stage[k-1].g_rest.a_q[rest_wid+SEG_WID-1:SEG_WID];
            assign b_d = g_stage[k-1].g_rest.b_q[rest_wid+SEG_WID-1:SEG_WID];
         end

         always_ff @(posedge Clock) begin
            if (Reset) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end else begin : g_last
         logic ovf_d;
         logic ovf_q;

         // Carry into the MSB is recovered from the MSB sum bit as a ^ b ^ s,
         // then compared with the carry out of the MSB.
         assign ovf_d = seg_res[SEG_WID]
                      ^ (seg_a[SEG_WID-1] ^ seg_b[SEG_WID-1] ^ seg_res[SEG_WID-1]);

         always_ff @(posedge Clock) begin
            if (Reset) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign OutValid    = g_stage[NUM_STAGES-1].vld_q;
   assign Sum         = g_stage[NUM_STAGES-1].sum_q;
   assign CarryOutput = g_stage[NUM_STAGES-1].cy_q;
   assign Overflow    = g_stage[NUM_STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_rca_addsub.sv
// tb_pipe_rca_addsub
//   Self-checking bench for pipe_rca_addsub (DATA_WID 64, SEG_WID 16).
//   A transaction-level reference model (plain wide arithmetic) predicts every
//   accepted operand set; a monitor compares results in order. Directed
//   sequences cover latency, carry ripple, back-to-back mixed modes,
//   back-pressure stability and reset flush.

module tb_pipe_rca_addsub;

   localparam int W   = 64;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   always #5 clk = ~clk;

   pipe_rca_addsub #(
      .DATA_WID (W),
      .SEG_WID  (16)
   ) dut (
      .Clock       (clk),
      .Reset       (rst),
      .InValid     (in_valid),
      .InReady     (in_ready),
      .InputA      (a),
      .InputB      (b),
      .CarryInput  (cin),
      .SubMode     (sub),
      .OutValid    (out_valid),
      .OutReady    (out_ready),
      .Sum         (sum),
      .CarryOutput (cout),
      .Overflow    (ovf)
   );

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Result of one operation from the arithmetic definition.
   function automatic res_t ref_model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                      input logic c_v, input logic s_v);
      logic [W:0]   ext;
      logic [W+1:0] ta;
      logic [W+1:0] tb;
      logic [W+1:0] tru;
      res_t         r;
      ta = {{2{a_v[W-1]}}, a_v};
      tb = {{2{b_v[W-1]}}, b_v};
      if (s_v) begin
         ext = {1'b0, a_v} - {1'b0, b_v} - {{W{1'b0}}, c_v};
         tru = ta - tb - {{(W+1){1'b0}}, c_v};
         r.c = ~ext[W];
      end else begin
         ext = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, c_v};
         tru = ta + tb + {{(W+1){1'b0}}, c_v};
         r.c = ext[W];
      end
      r.s = ext[W-1:0];
      // True signed result fits in W bits iff its top three bits agree.
      r.v = (tru[W+1:W-1] != 3'b000) && (tru[W+1:W-1] != 3'b111);
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b0, {(W-1){1'b1}}};
         3:       v = {1'b1, {(W-1){1'b0}}};
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Monitor: in-order scoreboard, sampled mid-cycle.
   res_t mon_r;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
               mon_r = exp_q.pop_front();
               check("mon_sum", sum, mon_r.s);
               check("mon_cout", 64'(cout), 64'(mon_r.c));
               check("mon_ovf", 64'(ovf), 64'(mon_r.v));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, cin, sub));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic c_v, input logic s_v);
      a        = a_v;
      b        = b_v;
      cin      = c_v;
      sub      = s_v;
      in_valid = 1'b1;
      check("issue_in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
   endtask

   // Waits for OutValid; lat counts edges since the first accepting edge.
   task automatic wait_valid(input int start, output int lat);
      lat = start;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic check_res(input string tag, input logic [W-1:0] s_v, input logic c_v,
                            input logic v_v);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_sum"}, sum, s_v);
      check({tag, "_cout"}, 64'(cout), 64'(c_v));
      check({tag, "_ovf"}, 64'(ovf), 64'(v_v));
   endtask

   task automatic single(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic c_v, input logic s_v, input logic [W-1:0] s_e,
                         input logic c_e, input logic v_e);
      int lat;
      issue(a_v, b_v, c_v, s_v);
      wait_valid(1, lat);
      check({tag, "_lat"}, 64'(lat), 64'(LAT));
      check_res(tag, s_e, c_e, v_e);
      tick();
      check({tag, "_drained"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int           lat;
      int           sent;
      int           base;
      int           stall_left;
      logic         acc;
      logic [W-1:0] snap_s;
      logic         snap_c;
      logic         snap_v;
      logic [W-1:0] sa [8];
      logic [W-1:0] sb [8];
      logic         sc [8];
      logic         ss [8];

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_sum", sum, 64'(0));
      check("rst_cout", 64'(cout), 64'(0));
      check("rst_ovf", 64'(ovf), 64'(0));
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", 64'(in_ready), 64'(1));

      // Basic add and full-width carry ripple.
      single("add_1_1", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);
      single("ripple", 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      single("sub_0_1", 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

      // Signed overflow add followed immediately by a subtract.
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      issue(64'd7, 64'd1, 1'b0, 1'b1);
      wait_valid(2, lat);
      check("b2b_lat", 64'(lat), 64'(LAT));
      check_res("b2b_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      tick();
      check_res("b2b_sub", 64'd6, 1'b1, 1'b0);
      tick();

      // Eight back-to-back operands with a 3-cycle stall on the third result.
      for (int i = 0; i < 8; i++) begin
         sa[i] = rnd_op();
         sb[i] = rnd_op();
         sc[i] = 1'($urandom_range(0, 1));
         ss[i] = 1'($urandom_range(0, 1));
      end
      sent       = 0;
      base       = n_out;
      stall_left = 3;
      for (int cyc = 0; cyc < 60 && (n_out - base) < 8; cyc++) begin
         if (out_valid && (n_out - base) == 2 && stall_left > 0) begin
            out_ready = 1'b0;
            #1;
            if (stall_left == 3) begin
               snap_s = sum;
               snap_c = cout;
               snap_v = ovf;
            end else begin
               check("stall_sum", sum, snap_s);
               check("stall_cout", 64'(cout), 64'(snap_c));
               check("stall_ovf", 64'(ovf), 64'(snap_v));
            end
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_valid", 64'(out_valid), 64'(1));
            stall_left--;
         end else begin
            out_ready = 1'b1;
            #1;
         end
         acc = 1'b0;
         if (sent < 8) begin
            a        = sa[sent];
            b        = sb[sent];
            cin      = sc[sent];
            sub      = ss[sent];
            in_valid = 1'b1;
            acc      = in_ready;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_sent", 64'(sent), 64'(8));
      check("stream_results", 64'(n_out - base), 64'(8));
      check("stream_stalled", 64'(stall_left), 64'(0));
      tick();

      // Reset with three operand sets in flight, plus one offered during reset.
      issue(64'd10, 64'd20, 1'b0, 1'b0);
      issue(64'd30, 64'd5, 1'b1, 1'b1);
      issue(64'hDEAD, 64'hBEEF, 1'b0, 1'b0);
      rst      = 1'b1;
      a        = 64'd99;
      b        = 64'd1;
      in_valid = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("flush_in_ready", 64'(in_ready), 64'(1));
      for (int i = 0; i < 8; i++) begin
         check("flush_valid", 64'(out_valid), 64'(0));
         tick();
      end
      single("after_flush", 64'd100, 64'd58, 1'b1, 1'b1, 64'd41, 1'b1, 1'b0);

      // Random traffic with random back-pressure, checked by the monitor.
      for (int cyc = 0; cyc < 300; cyc++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = rnd_op();
         b         = rnd_op();
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (LAT + 4) tick();
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      check("drain_valid", 64'(out_valid), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
